// File: rtl/fll_reg_pkg.sv
// ============================================================================
// fll_reg_pkg : address map, config record, reset values and FSM states
//               shared by the FLL register slave.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fll_reg_pkg;

   localparam logic [3:0] ADDR_STATUS   = 4'd0;
   localparam logic [3:0] ADDR_CFG_BASE = 4'd1;
   localparam logic [3:0] ADDR_GAIN     = 4'd8;
   localparam logic [3:0] ADDR_SCRATCH  = 4'd9;

   localparam logic [15:0] MULT_RST = 16'h05F5;
   localparam logic [3:0]  DIV_RST  = 4'd1;
   localparam logic [3:0]  GAIN_RST = 4'd7;

   // Bit order matches the CFG register layout, so a 22-bit slice casts directly
   typedef struct packed {
      logic        open_loop;
      logic        en;
      logic [3:0]  div;
      logic [15:0] mult;
   } fll_cfg_t;

   localparam fll_cfg_t CFG_RST = '{open_loop: 1'b1, en: 1'b0, div: DIV_RST, mult: MULT_RST};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK_HI = 2'd2
   } fll_state_t;

endpackage

`default_nettype wire

// File: rtl/fll_sync.sv
// ============================================================================
// fll_sync : SYNC_STAGES-deep flop synchronizer, async active-high reset to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fll_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= '0;
      else     ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fll_reg_slave.sv
// ============================================================================
// fll_reg_slave : FLL_BUS req/ack register endpoint holding per-clock FLL config.
//                 Optional sticky lock-loss flags + irq_o via FLL_REG_LOCK_IRQ_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fll_reg_slave
   import fll_reg_pkg::*;
#(
   parameter int NUM_CLK     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  web_i,
   input  logic [3:0]            addr_i,
   input  logic [31:0]           wdata_i,
   output logic                  ack_o,
   output logic [31:0]           rdata_o,
   input  logic [NUM_CLK-1:0]    lock_i,
   output logic [NUM_CLK*16-1:0] mult_o,
   output logic [NUM_CLK*4-1:0]  div_o,
   output logic [NUM_CLK-1:0]    en_o,
   output logic [NUM_CLK-1:0]    open_loop_o,
   output logic [3:0]            gain_o,
   output logic [NUM_CLK-1:0]    cfg_upd_o
`ifdef FLL_REG_LOCK_IRQ_EN
   ,
   output logic                  irq_o
`endif
);

   logic               req_s;
   logic [NUM_CLK-1:0] lock_s;

   fll_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk_i), .rst (rst_i), .d (req_i), .q (req_s)
   );

   generate
      for (genvar i = 0; i < NUM_CLK; i++) begin : g_lock_sync
         fll_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
            .clk (clk_i), .rst (rst_i), .d (lock_i[i]), .q (lock_s[i])
         );
      end
   endgenerate

   fll_state_t  state, state_nxt;
   logic        capture, do_access, ack_clear, do_write;
   logic        hold_web;
   logic [3:0]  hold_addr;
   logic [31:0] hold_wdata;
   fll_cfg_t    cfg [NUM_CLK];
   logic [3:0]  gain;
   logic [31:0] scratch;
   logic [31:0] rd_value;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_s) state_nxt = ACCESS;
         ACCESS:  state_nxt = ACK_HI;
         ACK_HI:  if (!req_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      capture   = (state == IDLE) && req_s;
      do_access = (state == ACCESS);
      ack_clear = (state == ACK_HI) && !req_s;
   end

   assign do_write = do_access && !hold_web;

   // The bridge zeroes addr/wdata after ack, so the request is latched on acceptance
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_web   <= 1'b1;
         hold_addr  <= '0;
         hold_wdata <= '0;
      end else if (capture) begin
         hold_web   <= web_i;
         hold_addr  <= addr_i;
         hold_wdata <= wdata_i;
      end
   end

`ifdef FLL_REG_LOCK_IRQ_EN
   logic [NUM_CLK-1:0] lock_d, lock_lost, lost_clr;

   assign lost_clr = (do_write && hold_addr == ADDR_STATUS) ? hold_wdata[NUM_CLK+3:4] : '0;

   // Set term is OR'ed in after the clear so a coincident loss stays flagged
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_d    <= '0;
         lock_lost <= '0;
         irq_o     <= 1'b0;
      end else begin
         lock_d    <= lock_s;
         lock_lost <= (lock_lost & ~lost_clr) | (lock_d & ~lock_s);
         irq_o     <= |lock_lost;
      end
   end
`endif

   always_comb begin
      rd_value = '0;
      if (hold_addr == ADDR_STATUS) begin
         rd_value[NUM_CLK-1:0] = lock_s;
`ifdef FLL_REG_LOCK_IRQ_EN
         rd_value[NUM_CLK+3:4] = lock_lost;
`endif
      end else if (hold_addr == ADDR_GAIN) begin
         rd_value[3:0] = gain;
      end else if (hold_addr == ADDR_SCRATCH) begin
         rd_value = scratch;
      end else begin
         for (int i = 0; i < NUM_CLK; i++)
            if (hold_addr == ADDR_CFG_BASE + 4'(i)) rd_value = 32'(cfg[i]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_o     <= 1'b0;
         rdata_o   <= '0;
         gain      <= GAIN_RST;
         scratch   <= '0;
         cfg_upd_o <= '0;
         for (int i = 0; i < NUM_CLK; i++) cfg[i] <= CFG_RST;
      end else begin
         cfg_upd_o <= '0;
         if (do_access)      ack_o <= 1'b1;
         else if (ack_clear) ack_o <= 1'b0;
         if (do_access && hold_web) rdata_o <= rd_value;
         if (do_write) begin
            if (hold_addr == ADDR_GAIN)    gain    <= hold_wdata[3:0];
            if (hold_addr == ADDR_SCRATCH) scratch <= hold_wdata;
            for (int i = 0; i < NUM_CLK; i++) begin
               if (hold_addr == ADDR_CFG_BASE + 4'(i)) begin
                  cfg[i]       <= fll_cfg_t'(hold_wdata[21:0]);
                  cfg_upd_o[i] <= 1'b1;
               end
            end
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM_CLK; i++) begin : g_cfg_out
         assign mult_o[i*16 +: 16] = cfg[i].mult;
         assign div_o[i*4 +: 4]    = cfg[i].div;
         assign en_o[i]            = cfg[i].en;
         assign open_loop_o[i]     = cfg[i].open_loop;
      end
   endgenerate

   assign gain_o = gain;

endmodule

`default_nettype wire
